// File: rtl/perf_report_ctrl.sv
// rtl/perf_report_ctrl.sv - windowed branch/IPC/memory performance counters with a report FIFO
module perf_report_fifo #(
    parameter int DW    = 34,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          accept
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign accept = push && (!full || do_pop);
    // Head is forced to zero while empty so outputs clear the moment reset empties us.
    assign rdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Read/write pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module perf_report_ctrl #(
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 16,
    parameter int DEF_WIN    = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_we,
    input  logic [WIN_W-1:0] i_cfg_win,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_br_inst,
    input  logic             i_br_correct,
    input  logic             i_inst_done,
    input  logic             i_lsu_valid,
    input  logic             i_lsu_ready,
    output logic             o_rpt_valid,
    input  logic             i_rpt_ready,
    output logic [1:0]       o_rpt_id,
    output logic [CNT_W-1:0] o_rpt_num,
    output logic [CNT_W-1:0] o_rpt_den,
    output logic             o_running,
    output logic [7:0]       o_drop_cnt
);
    localparam int RW = 2 + 2*CNT_W;
    localparam int MW = (WIN_W > CNT_W) ? WIN_W : CNT_W;
    localparam logic [WIN_W-1:0] MIN_WIN   = WIN_W'(4);
    localparam logic [WIN_W-1:0] DEF_WIN_V = WIN_W'(DEF_WIN);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    logic [WIN_W-1:0] win;
    logic [WIN_W-1:0] cyc;

    logic [CNT_W-1:0] br_num,  br_den,  ipc_num,  mem_num,  mem_den;
    logic [CNT_W-1:0] br_num_nx, br_den_nx, ipc_num_nx, mem_num_nx, mem_den_nx;

    logic [CNT_W-1:0] s_br_num, s_br_den, s_ipc_num, s_ipc_den, s_mem_num, s_mem_den;
    logic             emit_act;
    logic [1:0]       emit_idx;

    logic             win_end;
    logic [RW-1:0]    push_rec;
    logic [RW-1:0]    head_rec;
    logic             fifo_empty;
    logic             fifo_accept;
    logic             fifo_pop;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        sat_inc = (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Window length reported as the IPC denominator, clamped if it cannot fit CNT_W.
    function automatic logic [CNT_W-1:0] win_den(input logic [WIN_W-1:0] w);
        logic [MW-1:0] wx;
        logic [MW-1:0] lim;
        wx = MW'(w);
        lim = MW'({CNT_W{1'b1}});
        win_den = (wx > lim) ? '1 : CNT_W'(wx);
    endfunction

    // Last cycle of a window; a stop in that same cycle discards it instead.
    assign win_end = (state == RUN) && !i_stop && (cyc == win - WIN_W'(1));

    // Accumulator values including this cycle's events.
    always_comb begin
        br_den_nx  = sat_inc(br_den,  i_br_inst);
        br_num_nx  = sat_inc(br_num,  i_br_inst & i_br_correct);
        ipc_num_nx = sat_inc(ipc_num, i_inst_done);
        mem_den_nx = sat_inc(mem_den, i_lsu_valid);
        mem_num_nx = sat_inc(mem_num, i_lsu_valid & i_lsu_ready);
    end

    // Control FSM: window config, sampling state, cycle counter and accumulators.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            o_running <= 1'b0;
            win       <= DEF_WIN_V;
            cyc       <= '0;
            br_num    <= '0;
            br_den    <= '0;
            ipc_num   <= '0;
            mem_num   <= '0;
            mem_den   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cfg_we) win <= (i_cfg_win < MIN_WIN) ? MIN_WIN : i_cfg_win;
                    if (i_start && !i_stop) begin
                        state     <= RUN;
                        o_running <= 1'b1;
                        cyc       <= '0;
                        br_num    <= '0;
                        br_den    <= '0;
                        ipc_num   <= '0;
                        mem_num   <= '0;
                        mem_den   <= '0;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        state     <= IDLE;
                        o_running <= 1'b0;
                    end else if (win_end) begin
                        cyc     <= '0;
                        br_num  <= '0;
                        br_den  <= '0;
                        ipc_num <= '0;
                        mem_num <= '0;
                        mem_den <= '0;
                    end else begin
                        cyc     <= cyc + WIN_W'(1);
                        br_num  <= br_num_nx;
                        br_den  <= br_den_nx;
                        ipc_num <= ipc_num_nx;
                        mem_num <= mem_num_nx;
                        mem_den <= mem_den_nx;
                    end
                end
            endcase
        end
    end

    // Snapshot at window end, then emit one record per cycle; runs on even after a stop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            emit_act  <= 1'b0;
            emit_idx  <= 2'd0;
            s_br_num  <= '0;
            s_br_den  <= '0;
            s_ipc_num <= '0;
            s_ipc_den <= '0;
            s_mem_num <= '0;
            s_mem_den <= '0;
        end else if (win_end) begin
            emit_act  <= 1'b1;
            emit_idx  <= 2'd0;
            s_br_num  <= br_num_nx;
            s_br_den  <= br_den_nx;
            s_ipc_num <= ipc_num_nx;
            s_ipc_den <= win_den(win);
            s_mem_num <= mem_num_nx;
            s_mem_den <= mem_den_nx;
        end else if (emit_act) begin
            if (emit_idx == 2'd2) emit_act <= 1'b0;
            emit_idx <= emit_idx + 2'd1;
        end
    end

    // Record selected by the emitter slot: branch, IPC, memory.
    always_comb begin
        push_rec = '0;
        case (emit_idx)
            2'd0:    push_rec = {2'd0, s_br_num,  s_br_den};
            2'd1:    push_rec = {2'd1, s_ipc_num, s_ipc_den};
            default: push_rec = {2'd2, s_mem_num, s_mem_den};
        endcase
    end

    assign fifo_pop = o_rpt_valid && i_rpt_ready;

    perf_report_fifo #(
        .DW    (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .rst    (i_rst),
        .push   (emit_act),
        .wdata  (push_rec),
        .pop    (fifo_pop),
        .rdata  (head_rec),
        .empty  (fifo_empty),
        .accept (fifo_accept)
    );

    assign o_rpt_valid = !fifo_empty;
    assign o_rpt_id    = head_rec[RW-1 -: 2];
    assign o_rpt_num   = head_rec[2*CNT_W-1 -: CNT_W];
    assign o_rpt_den   = head_rec[CNT_W-1:0];

    // Saturating count of records the full FIFO turned away.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_drop_cnt <= 8'd0;
        end else if (emit_act && !fifo_accept && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_perf_report_ctrl.sv
// tb/tb_perf_report_ctrl.sv - scoreboard bench for perf_report_ctrl with a behavioural reference model
module tb_perf_report_ctrl;
    localparam int WIN_W   = 16;
    localparam int CNT_W   = 16;
    localparam int DEF_WIN = 1000;
    localparam int DEPTH   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, cfg_we, start, stop;
    logic [WIN_W-1:0] cfg_win;
    logic br_inst, br_correct, inst_done, lsu_valid, lsu_ready, rpt_ready;
    logic rpt_valid, running;
    logic [1:0] rpt_id;
    logic [CNT_W-1:0] rpt_num, rpt_den;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int id;
        int num;
        int den;
    } rec_t;

    rec_t mq[$];
    rec_t pend[$];
    rec_t got_q[$];
    rec_t tmp;

    bit m_run = 0;
    int m_cyc = 0;
    int m_win = DEF_WIN;
    int m_drop = 0;
    int s_bn = 0, s_bd = 0, s_in = 0, s_mn = 0, s_md = 0;

    always #5 clk = ~clk;

    perf_report_ctrl #(
        .WIN_W(WIN_W), .CNT_W(CNT_W), .DEF_WIN(DEF_WIN), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_win(cfg_win),
        .i_start(start), .i_stop(stop), .i_br_inst(br_inst), .i_br_correct(br_correct),
        .i_inst_done(inst_done), .i_lsu_valid(lsu_valid), .i_lsu_ready(lsu_ready),
        .o_rpt_valid(rpt_valid), .i_rpt_ready(rpt_ready), .o_rpt_id(rpt_id),
        .o_rpt_num(rpt_num), .o_rpt_den(rpt_den), .o_running(running), .o_drop_cnt(drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Reference model: window sums as plain integers, FIFO as a bounded queue.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            pend.delete();
            m_run = 0;
            m_cyc = 0;
            m_win = DEF_WIN;
            m_drop = 0;
        end else begin
            if (mq.size() > 0 && rpt_ready) void'(mq.pop_front());
            if (pend.size() > 0) begin
                tmp = pend.pop_front();
                if (mq.size() < DEPTH) mq.push_back(tmp);
                else if (m_drop < 255) m_drop++;
            end
            if (m_run) begin
                if (stop) begin
                    m_run = 0;
                end else begin
                    s_bd = sat(s_bd + int'(br_inst));
                    s_bn = sat(s_bn + int'(br_inst & br_correct));
                    s_in = sat(s_in + int'(inst_done));
                    s_md = sat(s_md + int'(lsu_valid));
                    s_mn = sat(s_mn + int'(lsu_valid & lsu_ready));
                    if (m_cyc == m_win - 1) begin
                        pend.push_back('{0, s_bn, s_bd});
                        pend.push_back('{1, s_in, m_win});
                        pend.push_back('{2, s_mn, s_md});
                        s_bn = 0; s_bd = 0; s_in = 0; s_mn = 0; s_md = 0;
                        m_cyc = 0;
                    end else begin
                        m_cyc++;
                    end
                end
            end else begin
                if (cfg_we) m_win = (int'(cfg_win) < 4) ? 4 : int'(cfg_win);
                if (start && !stop) begin
                    m_run = 1;
                    m_cyc = 0;
                    s_bn = 0; s_bd = 0; s_in = 0; s_mn = 0; s_md = 0;
                end
            end
        end
    end

    // Monitor: compares the DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", 32'(rpt_valid), 0);
            check("rst_running", 32'(running), 0);
            check("rst_drop", 32'(drop_cnt), 0);
        end else begin
            check("running", 32'(running), 32'(m_run));
            check("valid", 32'(rpt_valid), 32'(mq.size() > 0));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (rpt_valid && mq.size() > 0) begin
                check("head_id", 32'(rpt_id), 32'(mq[0].id));
                check("head_num", 32'(rpt_num), 32'(mq[0].num));
                check("head_den", 32'(rpt_den), 32'(mq[0].den));
            end
            if (rpt_valid && rpt_ready) got_q.push_back('{int'(rpt_id), int'(rpt_num), int'(rpt_den)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic idle_inputs();
        cfg_we = 0; start = 0; stop = 0;
        br_inst = 0; br_correct = 0; inst_done = 0; lsu_valid = 0; lsu_ready = 0;
    endtask

    task automatic cfg(input int w);
        cfg_we = 1;
        cfg_win = WIN_W'(w);
        tick();
        cfg_we = 0;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic do_stop();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic rand_ev();
        br_inst = 1'($urandom_range(0, 1));
        br_correct = 1'($urandom_range(0, 1));
        inst_done = 1'($urandom_range(0, 1));
        lsu_valid = 1'($urandom_range(0, 1));
        lsu_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_rec(input string name, input int idx, input int id, input int num, input int den);
        if (idx < got_q.size()) begin
            check({name, "_id"}, 32'(got_q[idx].id), 32'(id));
            check({name, "_num"}, 32'(got_q[idx].num), 32'(num));
            check({name, "_den"}, 32'(got_q[idx].den), 32'(den));
        end else begin
            check({name, "_present"}, 32'(got_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int n;
        rst = 1; cfg_win = '0; rpt_ready = 1;
        idle_inputs();
        cycles(2);
        rst = 0;
        cycles(2);

        // Directed window of 8 with known event counts; first valid at T+2.
        got_q.delete();
        cfg(8);
        do_start();
        for (int k = 0; k < 8; k++) begin
            inst_done = 1;
            br_inst = (k < 4);
            br_correct = (k < 3);
            lsu_valid = (k < 5);
            lsu_ready = (k < 2);
            tick();
        end
        idle_inputs();
        stop = 1;
        @(negedge clk);
        check("valid_at_T1", 32'(rpt_valid), 0);
        tick();
        stop = 0;
        @(negedge clk);
        check("valid_at_T2", 32'(rpt_valid), 1);
        cycles(6);
        check("win8_count", 32'(got_q.size()), 3);
        check_rec("win8_r0", 0, 0, 3, 4);
        check_rec("win8_r1", 1, 1, 8, 8);
        check_rec("win8_r2", 2, 2, 2, 5);

        // Small window clamp, cfg ignored while running, start&stop in IDLE.
        got_q.delete();
        cfg(2);
        inst_done = 1;
        do_start();
        tick();
        cfg(16);
        tick();
        tick();
        stop = 1;
        tick();
        idle_inputs();
        cycles(5);
        check("clamp_count", 32'(got_q.size()), 3);
        check_rec("clamp_ipc", 1, 1, 4, 4);
        start = 1; stop = 1;
        tick();
        idle_inputs();
        @(negedge clk);
        check("start_stop_idle", 32'(running), 0);
        tick();

        // Stop mid-window discards; restart counts from zero.
        got_q.delete();
        cfg(8);
        br_inst = 1; br_correct = 1; inst_done = 1; lsu_valid = 1; lsu_ready = 1;
        do_start();
        cycles(4);
        stop = 1;
        tick();
        stop = 0;
        @(negedge clk);
        check("stop_running", 32'(running), 0);
        cycles(12);
        check("stop_no_records", 32'(got_q.size()), 0);
        do_start();
        cycles(8);
        stop = 1;
        tick();
        idle_inputs();
        cycles(5);
        check_rec("restart_r0", 0, 0, 8, 8);
        check_rec("restart_r1", 1, 1, 8, 8);
        check_rec("restart_r2", 2, 2, 8, 8);

        // Backpressure: three windows of 4 into a 4-deep FIFO, then drain.
        rpt_ready = 0;
        cfg(4);
        do_start();
        for (int k = 0; k < 12; k++) begin
            rand_ev();
            tick();
        end
        idle_inputs();
        do_stop();
        cycles(5);
        check("drop_after_3win", 32'(drop_cnt), 5);
        got_q.delete();
        rpt_ready = 1;
        cycles(10);
        check("drain_count", 32'(got_q.size()), 4);
        for (int k = 0; k < 4 && k < got_q.size(); k++)
            check("drain_id", 32'(got_q[k].id), 32'(k % 3));

        // Asynchronous reset clears outputs without a clock edge.
        rpt_ready = 0;
        do_start();
        cycles(10);
        rst = 1;
        #1;
        check("async_valid", 32'(rpt_valid), 0);
        check("async_running", 32'(running), 0);
        check("async_drop", 32'(drop_cnt), 0);
        cycles(2);
        rst = 0;
        rpt_ready = 1;
        cycles(2);

        // Reset during emission abandons the remaining records.
        cfg(4);
        do_start();
        cycles(5);
        rst = 1;
        tick();
        rst = 0;
        got_q.delete();
        cycles(8);
        check("rst_emit_none", 32'(got_q.size()), 0);

        // Default window after reset.
        got_q.delete();
        do_start();
        for (int k = 0; k < DEF_WIN + 2; k++) begin
            rand_ev();
            tick();
        end
        idle_inputs();
        do_stop();
        cycles(6);
        if (got_q.size() >= 2) check("def_win_den", 32'(got_q[1].den), DEF_WIN);
        else check("def_win_count", 32'(got_q.size()), 3);

        // Randomized sessions checked by the model.
        for (int s = 0; s < 12; s++) begin
            idle_inputs();
            rpt_ready = 1;
            if ($urandom_range(0, 1) != 0) cfg(int'($urandom_range(0, 12)));
            if ($urandom_range(0, 3) == 0) begin
                start = 1; stop = 1;
                tick();
                start = 0; stop = 0;
            end
            do_start();
            n = int'($urandom_range(6, 48));
            for (int k = 0; k < n; k++) begin
                rand_ev();
                rpt_ready = ($urandom_range(0, 3) != 0);
                cfg_we = ($urandom_range(0, 9) == 0);
                cfg_win = WIN_W'($urandom_range(0, 12));
                start = ($urandom_range(0, 7) == 0);
                tick();
            end
            idle_inputs();
            do_stop();
            rpt_ready = 1;
            cycles(8);
        end

        // Full-length window with every cycle a correct branch.
        got_q.delete();
        cfg(65535);
        br_inst = 1; br_correct = 1;
        do_start();
        cycles(70000);
        idle_inputs();
        do_stop();
        cycles(6);
        check_rec("long_br", 0, 0, 65535, 65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
